hbm_param_bank: RTL

HBM_PARAM_BANK -- requirements
Module: hbm_param_bank

---
 rtl/hbm_param_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/hbm_param_bank.sv
// Double-buffered parameter bank: shadow registers loaded by writes, copied to active per channel on commit/done handshakes.
// Copy and start pulse on the edge after the triggering commit/done; readback one cycle after rd_en.
module hbm_param_bank #(
    parameter int ADDR_WIDTH = 33,
    parameter int NUM_CH     = 3,
    parameter int NUM_FIELDS = 11
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     wr_valid,
    input  logic [2:0]                               wr_ch,
    input  logic [3:0]                               wr_field,
    input  logic [ADDR_WIDTH-1:0]                    wr_data,
    input  logic [NUM_CH-1:0]                        commit,
    input  logic [NUM_CH-1:0]                        done,
    output logic [NUM_CH-1:0]                        start,
    output logic [NUM_CH-1:0]                        busy,
    output logic [NUM_CH*NUM_FIELDS*ADDR_WIDTH-1:0]  active_params,
    input  logic                                     rd_en,
    input  logic [2:0]                               rd_ch,
    input  logic [3:0]                               rd_field,
    input  logic                                     rd_active,
    output logic [ADDR_WIDTH-1:0]                    rd_data,
    output logic                                     wr_err
);

    typedef enum logic [1:0] {IDLE, RUN, RUN_PEND} state_t;

    logic [ADDR_WIDTH-1:0] shadow [NUM_CH][NUM_FIELDS];
    logic [ADDR_WIDTH-1:0] active [NUM_CH][NUM_FIELDS];
    state_t                state  [NUM_CH];

    logic                  wr_legal;
    logic                  wr_hit [NUM_CH][NUM_FIELDS];
    logic [NUM_CH-1:0]     copy;
    logic [ADDR_WIDTH-1:0] rd_sel;

    always_comb begin
        wr_legal = wr_valid && (int'(wr_ch) < NUM_CH) && (int'(wr_field) < NUM_FIELDS);
        for (int c = 0; c < NUM_CH; c++)
            for (int f = 0; f < NUM_FIELDS; f++)
                wr_hit[c][f] = wr_legal && (int'(wr_ch) == c) && (int'(wr_field) == f);
    end

    always_comb begin
        copy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            unique case (state[c])
                IDLE:     copy[c] = commit[c];
                RUN:      copy[c] = commit[c] & done[c];
                RUN_PEND: copy[c] = done[c];
                default:  copy[c] = 1'b0;
            endcase
        end
    end

    // No address match leaves rd_sel at zero, which covers out-of-range reads.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++)
            for (int f = 0; f < NUM_FIELDS; f++)
                if ((int'(rd_ch) == c) && (int'(rd_field) == f))
                    rd_sel = rd_active ? active[c][f] : shadow[c][f];
    end

    always_comb begin
        active_params = '0;
        busy          = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy[c] = (state[c] != IDLE);
            for (int f = 0; f < NUM_FIELDS; f++)
                active_params[(c*NUM_FIELDS+f)*ADDR_WIDTH +: ADDR_WIDTH] = active[c][f];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start   <= '0;
            wr_err  <= 1'b0;
            rd_data <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= IDLE;
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    shadow[c][f] <= '0;
                    active[c][f] <= '0;
                end
            end
        end else begin
            wr_err <= wr_valid && !wr_legal;
            start  <= copy;
            if (rd_en)
                rd_data <= rd_sel;
            for (int c = 0; c < NUM_CH; c++) begin
                unique case (state[c])
                    IDLE:     if (commit[c]) state[c] <= RUN;
                    RUN:      if (commit[c] && !done[c]) state[c] <= RUN_PEND;
                              else if (done[c] && !commit[c]) state[c] <= IDLE;
                    RUN_PEND: if (done[c]) state[c] <= RUN;
                    default:  state[c] <= IDLE;
                endcase
                // Copy forwards a same-cycle write so the new value lands in active.
                for (int f = 0; f < NUM_FIELDS; f++) begin
                    if (wr_hit[c][f])
                        shadow[c][f] <= wr_data;
                    if (copy[c])
                        active[c][f] <= wr_hit[c][f] ? wr_data : shadow[c][f];
                end
            end
        end
    end

endmodule
